// File: rtl/encoder_decoder_stream_pkg.sv
// Shared definitions for the encoder/decoder stream block: transform modes,
// LFSR feedback taps and the default keystream seed.
package encoder_decoder_stream_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_INV    = 2'b01,
    MODE_REV    = 2'b10,
    MODE_REVINV = 2'b11
  } mode_e;

  // Taps 16,14,13,11 expressed as a mask over lfsr[15:0]
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/encoder_decoder_stream_if.sv
// Handshake bundle between a stream producer/consumer (master) and the
// encoder/decoder block (slave).
interface encoder_decoder_stream_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic             in_dir;
  logic             in_valid;
  logic             in_ready;
  logic             resync;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      beat_count;

  modport master (
    output in_data, in_mode, in_dir, in_valid, resync, out_ready,
    input  in_ready, out_data, out_valid, beat_count
  );

  modport slave (
    input  in_data, in_mode, in_dir, in_valid, resync, out_ready,
    output in_ready, out_data, out_valid, beat_count
  );
endinterface

// File: rtl/encoder_decoder_stream_codec_transform.sv
// Combinational word transform: pass, invert, bit-reverse or reverse+invert.
module codec_transform
  import encoder_decoder_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] w_rev;

  for (genvar g = 0; g < WIDTH; g++) begin : g_rev
    assign w_rev[g] = i_data[WIDTH-1-g];
  end

  always_comb begin
    o_data = i_data;
    case (mode_e'(i_mode))
      MODE_PASS:   o_data = i_data;
      MODE_INV:    o_data = ~i_data;
      MODE_REV:    o_data = w_rev;
      MODE_REVINV: o_data = ~w_rev;
      default:     o_data = i_data;
    endcase
  end

endmodule

// File: rtl/encoder_decoder_stream.sv
// Single-register streaming encoder/decoder with optional LFSR keystream XOR
// and a running count of accepted input beats.
module encoder_decoder_stream
  import encoder_decoder_stream_pkg::*;
#(
  parameter int          WIDTH  = 8,
  parameter bit          KEY_EN = 1'b0,
  parameter logic [15:0] SEED   = DEFAULT_SEED
) (
  input  logic                    clk,
  input  logic                    rst,
  encoder_decoder_stream_if.slave bus
);

  logic [15:0]      r_lfsr;
  logic [15:0]      r_beatCount;
  logic [WIDTH-1:0] r_outData;
  logic             r_outValid;

  logic             w_inReady;
  logic             w_accept;
  logic [15:0]      w_lfsrCur;
  logic [15:0]      w_lfsrNext;
  logic [WIDTH-1:0] w_key;
  logic [WIDTH-1:0] w_xfIn;
  logic [WIDTH-1:0] w_xfOut;
  logic [WIDTH-1:0] w_result;

  assign w_inReady = !r_outValid || bus.out_ready;
  assign w_accept  = bus.in_valid && w_inReady;

  // A resync on an accepting beat keys that beat from SEED, not the stale state
  assign w_lfsrCur  = bus.resync ? SEED : r_lfsr;
  assign w_lfsrNext = {w_lfsrCur[14:0], ^(w_lfsrCur & LFSR_TAPS)};

  for (genvar g = 0; g < WIDTH; g++) begin : g_key
    assign w_key[g] = KEY_EN ? w_lfsrCur[g % 16] : 1'b0;
  end

  // Decode un-keys before the transform, encode keys after it, so they invert
  assign w_xfIn   = bus.in_dir ? (bus.in_data ^ w_key) : bus.in_data;
  assign w_result = bus.in_dir ? w_xfOut : (w_xfOut ^ w_key);

  codec_transform #(.WIDTH(WIDTH)) u_transform (
    .i_mode (bus.in_mode),
    .i_data (w_xfIn),
    .o_data (w_xfOut)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_outData   <= '0;
      r_outValid  <= 1'b0;
      r_lfsr      <= SEED;
      r_beatCount <= 16'd0;
    end else if (w_accept) begin
      r_outData   <= w_result;
      r_outValid  <= 1'b1;
      r_lfsr      <= w_lfsrNext;
      r_beatCount <= r_beatCount + 16'd1;
    end else begin
      if (bus.out_ready) r_outValid <= 1'b0;
      if (bus.resync)    r_lfsr     <= SEED;
    end
  end

  assign bus.in_ready   = w_inReady;
  assign bus.out_data   = r_outData;
  assign bus.out_valid  = r_outValid;
  assign bus.beat_count = r_beatCount;

endmodule

// File: tb/tb_encoder_decoder_stream.sv
// Self-checking bench: table vectors on an unkeyed instance, model-checked
// random and corner-case sequences on a keyed instance.
module tb_encoder_decoder_stream;
  import encoder_decoder_stream_pkg::*;

  localparam logic [15:0] TB_SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  encoder_decoder_stream_if #(.WIDTH(8)) if0 ();
  encoder_decoder_stream_if #(.WIDTH(8)) if1 ();

  encoder_decoder_stream #(.WIDTH(8), .KEY_EN(1'b0), .SEED(TB_SEED)) dut0 (
    .clk (clk), .rst (rst), .bus (if0.slave)
  );
  encoder_decoder_stream #(.WIDTH(8), .KEY_EN(1'b1), .SEED(TB_SEED)) dut1 (
    .clk (clk), .rst (rst), .bus (if1.slave)
  );

  int nChecks = 0;
  int nPass   = 0;

  logic [15:0] mLfsr;
  logic        mValid;
  logic [7:0]  mData;
  logic [15:0] mCount;

  typedef struct {
    logic [7:0] data;
    logic [1:0] mode;
    logic       dir;
    logic [7:0] expected;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] lfsrNext(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [7:0] xform(input logic [7:0] x, input logic [1:0] m);
    logic [7:0] r;
    r = x;
    if (m[1]) for (int i = 0; i < 8; i++) r[i] = x[7-i];
    if (m[0]) r = ~r;
    return r;
  endfunction

  task automatic modelReset();
    mLfsr = TB_SEED; mValid = 1'b0; mData = 8'h00; mCount = 16'd0;
  endtask

  // One cycle on the keyed instance, checked against the transaction model
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [1:0] m,
                               input logic dir, input logic rs, input logic ordy);
    logic        expReady, acc;
    logic [15:0] keySrc;
    logic [7:0]  k, res;
    if1.in_valid = v; if1.in_data = d; if1.in_mode = m;
    if1.in_dir = dir; if1.resync = rs; if1.out_ready = ordy;
    #1;
    expReady = !mValid || ordy;
    checkOutput("in_ready", {31'd0, if1.in_ready}, {31'd0, expReady});
    acc    = v && expReady;
    keySrc = rs ? TB_SEED : mLfsr;
    k      = keySrc[7:0];
    res    = dir ? xform(d ^ k, m) : (xform(d, m) ^ k);
    @(posedge clk); #1;
    if (acc) begin
      mValid = 1'b1; mData = res; mLfsr = lfsrNext(keySrc); mCount = mCount + 16'd1;
    end else begin
      if (ordy) mValid = 1'b0;
      if (rs)   mLfsr  = TB_SEED;
    end
    checkOutput("out_valid", {31'd0, if1.out_valid}, {31'd0, mValid});
    if (mValid) checkOutput("out_data", {24'd0, if1.out_data}, {24'd0, mData});
    checkOutput("beat_count", {16'd0, if1.beat_count}, {16'd0, mCount});
  endtask

  task automatic resetDut();
    rst = 1'b1;
    if0.in_valid = 1'b0; if1.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    vec_t vecs[$];
    logic [7:0] orig[$];
    logic [7:0] enc[$];
    logic [7:0] held;
    logic [15:0] cntBefore;

    if0.in_data = '0; if0.in_mode = '0; if0.in_dir = 0; if0.in_valid = 0;
    if0.resync = 0; if0.out_ready = 1;
    if1.in_data = '0; if1.in_mode = '0; if1.in_dir = 0; if1.in_valid = 0;
    if1.resync = 0; if1.out_ready = 1;

    vecs.push_back('{8'h01, 2'b11, 1'b0, 8'h7F});
    vecs.push_back('{8'hA5, 2'b11, 1'b0, 8'h5A});
    vecs.push_back('{8'hA5, 2'b00, 1'b0, 8'hA5});
    vecs.push_back('{8'hA5, 2'b01, 1'b0, 8'h5A});
    vecs.push_back('{8'h01, 2'b10, 1'b0, 8'h80});
    vecs.push_back('{8'h12, 2'b10, 1'b0, 8'h48});
    vecs.push_back('{8'h12, 2'b11, 1'b0, 8'hB7});
    vecs.push_back('{8'hF0, 2'b01, 1'b1, 8'h0F});
    vecs.push_back('{8'h80, 2'b10, 1'b1, 8'h01});
    vecs.push_back('{8'h3C, 2'b11, 1'b1, 8'hC3});

    resetDut();
    checkOutput("rst_out_valid0", {31'd0, if0.out_valid}, 32'd0);
    checkOutput("rst_out_data0", {24'd0, if0.out_data}, 32'd0);
    checkOutput("rst_in_ready0", {31'd0, if0.in_ready}, 32'd1);
    checkOutput("rst_out_valid1", {31'd0, if1.out_valid}, 32'd0);
    checkOutput("rst_beat1", {16'd0, if1.beat_count}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      if0.in_valid = 1'b1; if0.in_data = vecs[i].data;
      if0.in_mode = vecs[i].mode; if0.in_dir = vecs[i].dir;
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d_data", i), {24'd0, if0.out_data}, {24'd0, vecs[i].expected});
      checkOutput($sformatf("vec%0d_valid", i), {31'd0, if0.out_valid}, 32'd1);
    end
    if0.in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("vec_drain_valid", {31'd0, if0.out_valid}, 32'd0);
    checkOutput("vec_beats", {16'd0, if0.beat_count}, vecs.size());

    applyStimulus(1, 8'h00, MODE_PASS, 0, 0, 1);
    checkOutput("key_first", {24'd0, if1.out_data}, 32'hE1);
    applyStimulus(1, 8'h00, MODE_PASS, 0, 0, 1);
    checkOutput("key_second", {24'd0, if1.out_data}, 32'hC3);

    applyStimulus(1, 8'h11, MODE_PASS, 0, 0, 1);
    held = if1.out_data;
    cntBefore = if1.beat_count;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 8'($urandom), 2'($urandom), 1'($urandom), 0, 0);
      checkOutput("stall_hold", {24'd0, if1.out_data}, {24'd0, held});
    end
    checkOutput("stall_no_beats", {16'd0, if1.beat_count}, {16'd0, cntBefore});
    for (int i = 0; i < 4; i++) applyStimulus(1, 8'($urandom), 2'($urandom), 1'($urandom), 0, 1);
    checkOutput("release_beats", {16'd0, if1.beat_count}, {16'd0, cntBefore + 16'd4});

    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), 2'($urandom), 1'($urandom),
                    $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);

    applyStimulus(1, 8'h22, MODE_PASS, 0, 0, 1);
    applyStimulus(1, 8'h33, MODE_PASS, 0, 0, 0);
    if1.in_valid = 1'b1; if1.resync = 1'b1; if1.out_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    modelReset();
    checkOutput("midrst_valid", {31'd0, if1.out_valid}, 32'd0);
    checkOutput("midrst_beats", {16'd0, if1.beat_count}, 32'd0);
    checkOutput("midrst_data", {24'd0, if1.out_data}, 32'd0);
    applyStimulus(1, 8'h00, MODE_PASS, 0, 0, 1);
    checkOutput("midrst_key", {24'd0, if1.out_data}, 32'hE1);

    resetDut();
    for (int i = 0; i < 256; i++) begin
      orig.push_back(8'($urandom));
      applyStimulus(1, orig[i], MODE_REVINV, 0, 0, 1);
      enc.push_back(if1.out_data);
    end
    applyStimulus(0, 8'h00, MODE_REVINV, 1, 1, 1);
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1, enc[i], MODE_REVINV, 1, 0, 1);
      checkOutput($sformatf("roundtrip%0d", i), {24'd0, if1.out_data}, {24'd0, orig[i]});
    end
    checkOutput("roundtrip_beats", {16'd0, if1.beat_count}, 32'd512);

    resetDut();
    if1.in_valid = 1'b1; if1.out_ready = 1'b1; if1.resync = 1'b0;
    repeat (65535) @(posedge clk);
    #1;
    checkOutput("wrap_ffff", {16'd0, if1.beat_count}, 32'hFFFF);
    @(posedge clk); #1;
    checkOutput("wrap_zero", {16'd0, if1.beat_count}, 32'd0);
    if1.in_valid = 1'b0;

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/encoder_decoder_stream.md
ENCODER_DECODER_STREAM -- requirements
Module: encoder_decoder_stream

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=2).
REQ-002 Parameter KEY_EN, default 0, 1 enables LFSR keystream XOR.
REQ-003 Parameter SEED, default 16'hACE1, LFSR reset/resync value (nonzero).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_data  in  WIDTH  word to encode or decode.
REQ-007 in_mode  in  2  transform: 00 pass, 01 invert, 10 bit-reverse, 11 bit-reverse+invert.
REQ-008 in_dir  in  1  0 encode, 1 decode.
REQ-009 in_valid  in  1  input word present.
REQ-010 in_ready  out  1  block accepts input this cycle.
REQ-011 resync  in  1  reload LFSR with SEED.
REQ-012 out_data  out  WIDTH  transformed word.
REQ-013 out_valid  out  1  out_data valid.
REQ-014 out_ready  in  1  downstream accepts output.
REQ-015 beat_count  out  16  count of accepted input beats since reset.

Function
REQ-016 Input beat accepted when in_valid && in_ready; output beat delivered when out_valid && out_ready.
REQ-017 in_ready SHALL equal !out_valid || out_ready (single output register, full throughput).
REQ-018 Latency SHALL be exactly 1 cycle: accepted word appears on out_data with out_valid high next cycle.
REQ-019 in_data, in_mode, in_dir SHALL be sampled only at acceptance; later changes do not affect the held output.
REQ-020 While out_valid && !out_ready, out_data and out_valid SHALL hold stable.
REQ-021 Transform R(x) per in_mode: reverse maps bit i to bit WIDTH-1-i; invert is bitwise NOT; mode 11 applies both.
REQ-022 Key k = LFSR[WIDTH-1:0] when WIDTH<=16, else LFSR replicated to fill WIDTH; k = 0 when KEY_EN=0.
REQ-023 Encode: out = R(x) ^ k; decode: out = R(x ^ k); encode then decode with same mode and key SHALL return x.
REQ-024 LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts left once per accepted beat, feedback into bit 0.
REQ-025 resync without acceptance SHALL load SEED; resync with acceptance SHALL use key from SEED for that beat and leave LFSR at SEED advanced once.
REQ-026 beat_count SHALL increment by 1 per accepted beat and wrap 16'hFFFF -> 0.
REQ-027 Simultaneous output delivery and input acceptance SHALL replace out_data with the new word, out_valid stays 1.

Reset
REQ-028 On rst: out_valid=0, out_data=0, beat_count=0, LFSR=SEED; in_ready reads 1 the cycle after.
REQ-029 rst SHALL override all other inputs including resync and in-flight handshakes; held word is discarded.

Structure
REQ-030 Shared package holds mode encodings (MODE_PASS, MODE_INV, MODE_REV, MODE_REVINV), LFSR tap constant, default SEED.
REQ-031 Combinational transform R is a sub-module codec_transform (WIDTH, mode in, data in/out), used twice-free via a single instance on the pre- or post-XOR path selected by dir.
REQ-032 LFSR and beat counter live in the top module.

Verification
REQ-033 WIDTH=8, KEY_EN=0, mode 11, encode 8'h01 -> out_data 8'h7F one cycle later; 8'hA5 -> 8'h5A.
REQ-034 KEY_EN=1, SEED=16'hACE1, after reset mode 00 encode 8'h00 -> 8'hE1; second beat uses LFSR advanced once.
REQ-035 Roundtrip: stream 256 words encode (mode 11, KEY_EN=1), resync, decode stream -> original 256 words, beat_count=512.
REQ-036 out_ready held low 5 cycles with in_valid high -> in_ready low, out_data stable, no beat lost or duplicated; release -> 1 word/cycle.
REQ-037 rst asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, beat_count=0, first post-reset key = SEED low bits.
REQ-038 beat_count preset path: 65536 accepted beats -> beat_count wraps to 0.
